// File: rtl/mock_cgra_pipe.sv
// mock_cgra_pipe: a small configurable pipe with an IDLE/CONFIG/RUN/DRAIN controller
// and NUM_CH independent channels. Each channel applies a per-channel op
// (pass, add K, invert, discard) to its input and buffers the result in a DEPTH-entry FIFO.

// Per-channel transform and FIFO.
module mock_cgra_pipe_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,       // controller is in RUN: inputs may be accepted
    input  logic                  active,    // controller is in RUN or DRAIN: outputs may be presented
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] k,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [PW-1:0]                    wr_ptr;
    logic [PW-1:0]                    rd_ptr;
    logic [CW-1:0]                    count;
    logic [DATA_WIDTH-1:0]            xf;
    logic                             push;
    logic                             pop;

    // Ready looks only at occupancy, never at out_ready, so there is no comb path through the lane.
    assign in_ready  = run && (count < CW'(DEPTH));
    assign out_valid = active && (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign empty     = (count == '0);
    // Discarded words complete the input handshake but never reach the FIFO.
    assign push      = in_valid && in_ready && (op != 2'b11);
    assign pop       = out_valid && out_ready;

    // Per-channel operation; the add wraps at the word width.
    always_comb begin
        xf = in_data;
        case (op)
            2'b01:   xf = in_data + k;
            2'b10:   xf = ~in_data;
            default: xf = in_data;
        endcase
    end

    // FIFO storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= xf;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module mock_cgra_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 2,
    parameter int CFG_WIDTH  = 160
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]            data_in_valid,
    output logic [NUM_CH-1:0]            data_in_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            data_out_valid,
    input  logic [NUM_CH-1:0]            data_out_ready,
    input  logic [CFG_WIDTH-1:0]         config_bitstream,
    input  logic                         bitstream_enable_i,
    input  logic                         execute_i,
    output logic                         busy_o,
    output logic                         cfg_loaded_o
);
    // K in the low word, then two op bits per channel; anything above is ignored.
    localparam int CFG_USED = 32 + 2 * NUM_CH;

    if (CFG_WIDTH < CFG_USED) begin : g_chk_cfg
        $error("mock_cgra_pipe: CFG_WIDTH must be at least 32+2*NUM_CH");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("mock_cgra_pipe: DEPTH must be a power of two and at least 2");
    end
    if (CFG_WIDTH > CFG_USED) begin : g_cfg_pad
        logic cfg_unused;
        assign cfg_unused = ^config_bitstream[CFG_WIDTH-1:CFG_USED];
    end

    typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_RUN, S_DRAIN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CFG_USED-1:0]   cfg_q;
    logic                  cfg_loaded_q;
    logic [NUM_CH-1:0]     lane_empty;
    logic                  run;
    logic                  active;

    assign run          = (state == S_RUN);
    assign active       = (state == S_RUN) || (state == S_DRAIN);
    assign busy_o       = active;
    assign cfg_loaded_o = cfg_loaded_q;

    // Next state: configuration wins over execute in IDLE; DRAIN leaves only once every FIFO is empty.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bitstream_enable_i) begin
                    state_nxt = S_CONFIG;
                end else if (execute_i) begin
                    state_nxt = S_RUN;
                end
            end
            S_CONFIG: state_nxt = S_IDLE;
            S_RUN:    if (!execute_i) state_nxt = S_DRAIN;
            S_DRAIN:  if (&lane_empty) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Configuration is captured on the edge that enters CONFIG, so it is stable by the next RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q        <= '0;
            cfg_loaded_q <= 1'b0;
        end else if (state == S_IDLE && bitstream_enable_i) begin
            cfg_q        <= config_bitstream[CFG_USED-1:0];
            cfg_loaded_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        mock_cgra_pipe_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run),
            .active   (active),
            .op       (cfg_q[32+2*i +: 2]),
            .k        (cfg_q[31:0]),
            .in_data  (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .in_valid (data_in_valid[i]),
            .in_ready (data_in_ready[i]),
            .out_data (data_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .out_valid(data_out_valid[i]),
            .out_ready(data_out_ready[i]),
            .empty    (lane_empty[i])
        );
    end
endmodule

// File: tb/tb_mock_cgra_pipe.sv
// Self-checking bench for mock_cgra_pipe: per-channel word queues plus a four-mode
// controller model predict every output each cycle.
`timescale 1ns/1ps
module tb_mock_cgra_pipe;
    localparam int DW    = 32;
    localparam int NCH   = 4;
    localparam int DEPTH = 2;
    localparam int CFGW  = 160;
    localparam int SW    = NCH*DW + 2*NCH + 2;
    localparam int M_IDLE = 0, M_CONFIG = 1, M_RUN = 2, M_DRAIN = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH*DW-1:0] data_in = '0;
    logic [NCH-1:0]    data_in_valid = '0;
    logic [NCH-1:0]    data_in_ready;
    logic [NCH*DW-1:0] data_out;
    logic [NCH-1:0]    data_out_valid;
    logic [NCH-1:0]    data_out_ready = '1;
    logic [CFGW-1:0]   config_bitstream = '0;
    logic              bitstream_enable_i = 1'b0;
    logic              execute_i = 1'b0;
    logic              busy_o;
    logic              cfg_loaded_o;

    always #5 clk = ~clk;

    mock_cgra_pipe #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEPTH), .CFG_WIDTH(CFGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .config_bitstream(config_bitstream), .bitstream_enable_i(bitstream_enable_i),
        .execute_i(execute_i), .busy_o(busy_o), .cfg_loaded_o(cfg_loaded_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model
    logic [DW-1:0]   q [NCH][$];
    int              mode;
    logic [CFGW-1:0] cfg_m;
    logic            loaded_m;

    function automatic logic [DW-1:0] xform(input logic [1:0] op, input logic [DW-1:0] k,
                                            input logic [DW-1:0] d);
        case (op)
            2'b01:   return d + k;
            2'b10:   return ~d;
            default: return d;
        endcase
    endfunction

    function automatic logic [SW-1:0] expv();
        logic [NCH-1:0]    rdy, vld;
        logic [NCH*DW-1:0] dat;
        logic              bsy;
        rdy = '0; vld = '0; dat = '0;
        bsy = (mode == M_RUN) || (mode == M_DRAIN);
        for (int c = 0; c < NCH; c++) begin
            rdy[c] = (mode == M_RUN) && (q[c].size() < DEPTH);
            vld[c] = bsy && (q[c].size() > 0);
            if (vld[c]) dat[c*DW +: DW] = q[c][0];
        end
        return {rdy, vld, dat, bsy, loaded_m};
    endfunction

    function automatic logic [SW-1:0] obs();
        return {data_in_ready, data_out_valid, data_out, busy_o, cfg_loaded_o};
    endfunction

    task automatic model_reset();
        mode = M_IDLE; cfg_m = '0; loaded_m = 1'b0;
        for (int c = 0; c < NCH; c++) q[c].delete();
    endtask

    // Advance one clock: update the model from the inputs seen at the edge, return at the falling edge.
    task automatic tick();
        logic [NCH-1:0] rdy, vld;
        logic           all_empty;
        @(posedge clk);
        all_empty = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            rdy[c] = (mode == M_RUN) && (q[c].size() < DEPTH);
            vld[c] = (mode == M_RUN || mode == M_DRAIN) && (q[c].size() > 0);
            if (q[c].size() != 0) all_empty = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (vld[c] && data_out_ready[c]) void'(q[c].pop_front());
            if (rdy[c] && data_in_valid[c] && cfg_m[32+2*c +: 2] != 2'b11)
                q[c].push_back(xform(cfg_m[32+2*c +: 2], cfg_m[31:0], data_in[c*DW +: DW]));
        end
        case (mode)
            M_IDLE: begin
                if (bitstream_enable_i) begin
                    cfg_m = config_bitstream; loaded_m = 1'b1; mode = M_CONFIG;
                end else if (execute_i) mode = M_RUN;
            end
            M_CONFIG: mode = M_IDLE;
            M_RUN:    if (!execute_i) mode = M_DRAIN;
            default:  if (all_empty) mode = M_IDLE;
        endcase
        @(negedge clk);
    endtask

    task automatic go_idle();
        execute_i = 1'b0; bitstream_enable_i = 1'b0; data_in_valid = '0; data_out_ready = '1;
        for (int n = 0; n < 20 && mode != M_IDLE; n++) tick();
    endtask

    task automatic load_cfg(input logic [CFGW-1:0] v);
        config_bitstream = v; bitstream_enable_i = 1'b1;
        tick();
        bitstream_enable_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; data_in_valid = '1; execute_i = 1'b1; bitstream_enable_i = 1'b1;
        config_bitstream = '1; data_in = '1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({data_in_ready, data_out_valid, busy_o, cfg_loaded_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 0", {data_in_ready, data_out_valid, busy_o, cfg_loaded_o});
        end
        vectors++;
        if (data_out !== '0) begin
            miscompares++; $display("FAIL reset_data: got %h required 0", data_out);
        end
        @(negedge clk);
        data_in_valid = '0; execute_i = 1'b0; bitstream_enable_i = 1'b0; config_bitstream = '0;
        data_in = '0; rst_n = 1'b1;
        model_reset();
        tick();
        #1 vectors++;
        if (obs() !== expv()) begin
            miscompares++; $display("FAIL reset_release: got %h required %h", obs(), expv());
        end
    endtask

    task automatic test_passthrough();
        logic [DW-1:0] w [3];
        w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
        execute_i = 1'b1; data_out_ready = '1;
        tick();
        for (int n = 0; n < 3; n++) begin
            data_in = '0; data_in[0 +: DW] = w[n]; data_in_valid = 4'b0001;
            #1 vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL pass_offer%0d: got %h required %h", n, obs(), expv());
            end
            tick();
            data_in_valid = '0;
            #1 vectors++;
            if (data_out_valid[0] !== 1'b1 || data_out[0 +: DW] !== w[n]) begin
                miscompares++;
                $display("FAIL pass_word%0d: got v=%b d=%h required v=1 d=%h", n, data_out_valid[0], data_out[0 +: DW], w[n]);
            end
            tick();
        end
        #1 vectors++;
        if (data_out_valid[0] !== 1'b0) begin
            miscompares++; $display("FAIL pass_empty: got v=%b required 0", data_out_valid[0]);
        end
        go_idle();
    endtask

    task automatic test_config_ops();
        logic [CFGW-1:0] cfg;
        cfg = '0; cfg[31:0] = 32'd5; cfg[39:32] = 8'b00_11_10_01;
        config_bitstream = cfg; bitstream_enable_i = 1'b1;
        tick();
        bitstream_enable_i = 1'b0;
        #1 vectors++;
        if (cfg_loaded_o !== 1'b1 || busy_o !== 1'b0) begin
            miscompares++; $display("FAIL cfg_loaded: got loaded=%b busy=%b required 1 0", cfg_loaded_o, busy_o);
        end
        tick();
        execute_i = 1'b1;
        tick();
        data_in = {4{32'hFFFFFFFE}}; data_in_valid = '1; data_out_ready = '1;
        #1 vectors++;
        if (obs() !== expv()) begin
            miscompares++; $display("FAIL ops_offer: got %h required %h", obs(), expv());
        end
        tick();
        data_in_valid = '0;
        #1 vectors++;
        if (data_out_valid !== 4'b1011) begin
            miscompares++; $display("FAIL ops_valid: got %b required 1011", data_out_valid);
        end
        vectors++;
        if (data_out !== {32'hFFFFFFFE, 32'h0, 32'h1, 32'h3}) begin
            miscompares++; $display("FAIL ops_data: got %h required fffffffe_00000000_00000001_00000003", data_out);
        end
        tick();
        #1 vectors++;
        if (obs() !== expv()) begin
            miscompares++; $display("FAIL ops_after: got %h required %h", obs(), expv());
        end
        go_idle();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w [3];
        logic [DW-1:0] got [$];
        int            idx;
        logic          acc;
        idx = 0;
        load_cfg('0);
        for (int k = 0; k < 3; k++) w[k] = $urandom;
        execute_i = 1'b1;
        tick();
        data_out_ready = 4'b1101;
        for (int n = 0; n < 6; n++) begin
            data_in[DW +: DW] = w[idx]; data_in[0 +: DW] = $urandom;
            data_in_valid = 4'b0010; data_in_valid[0] = 1'($urandom);
            #1 vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL bp_stall%0d: got %h required %h", n, obs(), expv());
            end
            acc = (q[1].size() < DEPTH);
            tick();
            if (acc) idx++;
        end
        #1 vectors++;
        if (data_in_ready[1] !== 1'b0 || data_out_valid[1] !== 1'b1 || data_out[DW +: DW] !== w[0]) begin
            miscompares++;
            $display("FAIL bp_full: got rdy=%b v=%b d=%h required 0 1 %h", data_in_ready[1], data_out_valid[1], data_out[DW +: DW], w[0]);
        end
        data_out_ready = '1;
        for (int n = 0; n < 8; n++) begin
            data_in[DW +: DW] = w[idx < 3 ? idx : 2]; data_in[0 +: DW] = $urandom;
            data_in_valid = '0; data_in_valid[1] = (idx < 3); data_in_valid[0] = 1'($urandom);
            #1 vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL bp_release%0d: got %h required %h", n, obs(), expv());
            end
            if (data_out_valid[1] && data_out_ready[1]) got.push_back(data_out[DW +: DW]);
            acc = (idx < 3) && (q[1].size() < DEPTH);
            tick();
            if (acc) idx++;
        end
        vectors++;
        if (got.size() != 3 || got[0] !== w[0] || got[1] !== w[1] || got[2] !== w[2]) begin
            miscompares++; $display("FAIL bp_order: got %0d words required 3 in order %h %h %h", got.size(), w[0], w[1], w[2]);
        end
        go_idle();
    endtask

    task automatic test_push_pop();
        logic [DW-1:0] w [10];
        for (int n = 0; n < 10; n++) w[n] = $urandom;
        execute_i = 1'b1; data_out_ready = '1;
        tick();
        for (int n = 0; n < 10; n++) begin
            data_in[0 +: DW] = w[n]; data_in_valid = 4'b0001;
            #1 vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL pp_cycle%0d: got %h required %h", n, obs(), expv());
            end
            if (n > 0) begin
                vectors++;
                if (data_out_valid[0] !== 1'b1 || data_in_ready[0] !== 1'b1 || data_out[0 +: DW] !== w[n-1]) begin
                    miscompares++;
                    $display("FAIL pp_word%0d: got v=%b r=%b d=%h required 1 1 %h", n, data_out_valid[0], data_in_ready[0], data_out[0 +: DW], w[n-1]);
                end
            end
            tick();
        end
        data_in_valid = '0;
        #1 vectors++;
        if (data_out[0 +: DW] !== w[9]) begin
            miscompares++; $display("FAIL pp_last: got %h required %h", data_out[0 +: DW], w[9]);
        end
        tick();
        go_idle();
    endtask

    task automatic test_drain_priority();
        logic [DW-1:0] w0, w1, w2;
        w0 = $urandom; w1 = $urandom; w2 = $urandom;
        execute_i = 1'b1;
        tick();
        data_out_ready = 4'b1011; data_in[2*DW +: DW] = w0; data_in_valid = 4'b0100;
        tick();
        data_in[2*DW +: DW] = w1;
        tick();
        data_in_valid = '0; execute_i = 1'b0; bitstream_enable_i = 1'b1; config_bitstream = '1;
        tick();
        for (int n = 0; n < 2; n++) begin
            #1 vectors++;
            if (busy_o !== 1'b1 || data_out_valid !== 4'b0100) begin
                miscompares++; $display("FAIL drain_hold%0d: got busy=%b v=%b required 1 0100", n, busy_o, data_out_valid);
            end
            tick();
        end
        data_out_ready = '1;
        #1 vectors++;
        if (data_out[2*DW +: DW] !== w0) begin
            miscompares++; $display("FAIL drain_w0: got %h required %h", data_out[2*DW +: DW], w0);
        end
        tick();
        #1 vectors++;
        if (data_out[2*DW +: DW] !== w1 || busy_o !== 1'b1) begin
            miscompares++; $display("FAIL drain_w1: got %h busy=%b required %h 1", data_out[2*DW +: DW], busy_o, w1);
        end
        tick();
        bitstream_enable_i = 1'b0;
        #1 vectors++;
        if (busy_o !== 1'b1 || data_out_valid !== 4'b0000) begin
            miscompares++; $display("FAIL drain_tail: got busy=%b v=%b required 1 0000", busy_o, data_out_valid);
        end
        tick();
        #1 vectors++;
        if (busy_o !== 1'b0 || obs() !== expv()) begin
            miscompares++; $display("FAIL drain_idle: got %h required %h", obs(), expv());
        end
        // The enable seen during DRAIN must not have changed the ops: ch2 still passes words through.
        execute_i = 1'b1;
        tick();
        data_in[2*DW +: DW] = w2; data_in_valid = 4'b0100;
        tick();
        data_in_valid = '0;
        #1 vectors++;
        if (data_out[2*DW +: DW] !== w2 || data_out_valid[2] !== 1'b1) begin
            miscompares++; $display("FAIL drain_cfg_kept: got %h required %h", data_out[2*DW +: DW], w2);
        end
        go_idle();
        config_bitstream = '0; bitstream_enable_i = 1'b1; execute_i = 1'b1;
        tick();
        bitstream_enable_i = 1'b0;
        #1 vectors++;
        if (busy_o !== 1'b0 || data_in_ready !== 4'b0000) begin
            miscompares++; $display("FAIL prio_config: got busy=%b rdy=%b required 0 0000", busy_o, data_in_ready);
        end
        tick();
        tick();
        #1 vectors++;
        if (busy_o !== 1'b1 || obs() !== expv()) begin
            miscompares++; $display("FAIL prio_run: got %h required %h", obs(), expv());
        end
        go_idle();
    endtask

    task automatic test_random();
        logic [CFGW-1:0] cfg;
        cfg = '0; cfg[31:0] = $urandom; cfg[32 +: 2*NCH] = 8'($urandom);
        load_cfg(cfg);
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NCH; c++) data_in[c*DW +: DW] = $urandom;
            data_in_valid = 4'($urandom); data_out_ready = 4'($urandom);
            bitstream_enable_i = ($urandom_range(0, 15) == 0);
            config_bitstream = {5{$urandom}};
            execute_i = (n < 380) && ($urandom_range(0, 9) != 0);
            #1 vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL rand_cycle%0d: got %h required %h", n, obs(), expv());
            end
            tick();
        end
        go_idle();
        #1 vectors++;
        if (obs() !== expv()) begin
            miscompares++; $display("FAIL rand_end: got %h required %h", obs(), expv());
        end
    endtask

    task automatic test_reset_mid_run();
        logic [CFGW-1:0] cfg;
        logic [DW-1:0]   w;
        cfg = '0; cfg[31:0] = 32'd7; cfg[39:32] = 8'hAA;
        load_cfg(cfg);
        execute_i = 1'b1;
        tick();
        data_out_ready = '0; data_in_valid = '1;
        for (int c = 0; c < NCH; c++) data_in[c*DW +: DW] = $urandom;
        tick();
        data_in_valid = '0;
        #1 vectors++;
        if (obs() !== expv()) begin
            miscompares++; $display("FAIL rst_pre: got %h required %h", obs(), expv());
        end
        rst_n = 1'b0;
        #1 vectors++;
        if (data_out_valid !== '0 || data_out !== '0 || busy_o !== 1'b0 || cfg_loaded_o !== 1'b0 || data_in_ready !== '0) begin
            miscompares++; $display("FAIL rst_async: got v=%b busy=%b loaded=%b required all 0", data_out_valid, busy_o, cfg_loaded_o);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; data_out_ready = '1;
        tick();
        #1 vectors++;
        if (data_out_valid !== '0 || busy_o !== 1'b1) begin
            miscompares++; $display("FAIL rst_stale: got v=%b busy=%b required 0000 1", data_out_valid, busy_o);
        end
        w = $urandom;
        data_in[0 +: DW] = w; data_in_valid = 4'b0001;
        tick();
        data_in_valid = '0;
        #1 vectors++;
        if (data_out[0 +: DW] !== w || obs() !== expv()) begin
            miscompares++; $display("FAIL rst_pass: got %h required %h", data_out[0 +: DW], w);
        end
        go_idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_passthrough();
        test_config_ops();
        test_backpressure();
        test_push_pop();
        test_drain_priority();
        test_random();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
